// File: rtl/imm_encoder.sv
// Immediate encoder: packs an RV32 immediate into the immediate bit positions
// of a base instruction. Two-stage valid/ready pipeline. Stage 1 captures the
// request and precomputes whether the immediate is encodable. Stage 2 holds the
// packed instruction and error flag. Also counts emitted and erroneous results.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSel,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst_out,
  output logic             range_err,
  output logic [CNT_W-1:0] emit_cnt,
  output logic [7:0]       err_cnt
);

  localparam logic [2:0] SEL_I = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_J = 3'b011;
  localparam logic [2:0] SEL_S = 3'b100;
  localparam logic [2:0] SEL_U = 3'b101;

  // True when the immediate is too wide or misaligned for the selected format.
  function automatic logic range_bad(input logic [2:0] sel, input logic signed [31:0] v);
    logic bad;
    bad = 1'b0;
    case (sel)
      SEL_I, SEL_S: bad = (v < -32'sd2048) || (v > 32'sd2047);
      SEL_B:        bad = (v < -32'sd4096) || (v > 32'sd4095) || v[0];
      SEL_J:        bad = (v < -32'sd1048576) || (v > 32'sd1048575) || v[0];
      SEL_U:        bad = (v[11:0] != 12'h000);
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Scatter the immediate into its format's bit positions; other bits come from base.
  function automatic logic [31:0] pack(input logic [2:0] sel, input logic [31:0] v,
                                       input logic [31:0] base);
    logic [31:0] r;
    r = base;
    case (sel)
      SEL_I: r[31:20] = v[11:0];
      SEL_S: begin
        r[31:25] = v[11:5];
        r[11:7]  = v[4:0];
      end
      SEL_B: begin
        r[31]    = v[12];
        r[30:25] = v[10:5];
        r[11:8]  = v[4:1];
        r[7]     = v[11];
      end
      SEL_J: begin
        r[31]    = v[20];
        r[30:21] = v[10:1];
        r[20]    = v[11];
        r[19:12] = v[19:12];
      end
      SEL_U:   r[31:12] = v[31:12];
      default: r = base;
    endcase
    return r;
  endfunction

  logic              vld_p1;
  logic [2:0]        sel_p1;
  logic signed [31:0] imm_p1;
  logic [31:0]       base_p1;
  logic              bad_p1;
  logic              vld_p2;
  logic [31:0]       inst_p2;
  logic              err_p2;
  logic              rdy_p1;
  logic              rdy_p2;
  logic              out_hs;

  assign rdy_p2    = !vld_p2 || out_ready;
  assign rdy_p1    = !vld_p1 || rdy_p2;
  assign in_ready  = rdy_p1 && !rst;
  assign out_valid = vld_p2;
  assign inst_out  = inst_p2;
  assign range_err = err_p2;
  assign out_hs    = vld_p2 && out_ready;

  // ---- stage 1: request capture and range check ----
  // Stage 1 valid advances whenever stage 1 can accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (rdy_p1) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage 1 payload loads only on an accepted request; it is qualified by vld_p1.
  always_ff @(posedge clk) begin
    if (rdy_p1 && in_valid) begin
      sel_p1  <= ImmSel;
      imm_p1  <= imm;
      base_p1 <= base_inst;
      bad_p1  <= range_bad(ImmSel, imm);
    end
  end

  // ---- stage 2: packed instruction and error flag ----
  // Stage 2 holds its result while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      inst_p2 <= 32'h0;
      err_p2  <= 1'b0;
    end else if (rdy_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        inst_p2 <= pack(sel_p1, imm_p1, base_p1);
        err_p2  <= bad_p1;
      end
    end
  end

  // Handshake counters: emit count wraps, error count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emit_cnt <= '0;
      err_cnt  <= 8'h00;
    end else if (out_hs) begin
      emit_cnt <= emit_cnt + CNT_W'(1);
      if (err_p2 && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the emitted-instruction counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-006 SHALL have port ImmSel  input  3  immediate type: 001 I, 010 B, 011 J, 100 S, 101 U; any other value means none.
REQ-007 SHALL have port imm  input  32  byte-offset or value to encode.
REQ-008 SHALL have port base_inst  input  32  instruction carrying opcode, rd, rs1, rs2 and funct fields; its immediate bit positions are overwritten.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer ready.
REQ-011 SHALL have port inst_out  output  32  encoded instruction.
REQ-012 SHALL have port range_err  output  1  imm not encodable for ImmSel; qualified by out_valid.
REQ-013 SHALL have port emit_cnt  output  CNT_W  count of completed output handshakes.
REQ-014 SHALL have port err_cnt  output  8  count of handshakes with range_err=1, saturating.

Function
REQ-015 SHALL be a 2-stage valid/ready pipeline: S1 registers ImmSel/imm/base_inst plus range check; S2 registers packed inst_out and range_err.
REQ-016 SHALL set stage ready = !stage_valid || downstream_ready; in_ready = S1 ready; no combinational path from in_valid to out_valid.
REQ-017 SHALL give latency of exactly 2 cycles from accept to out_valid with out_ready held high; throughput 1 per cycle.
REQ-018 SHALL hold inst_out and range_err stable while out_valid && !out_ready.
REQ-019 SHALL pack I as inst[31:20]=imm[11:0].
REQ-020 SHALL pack S as inst[31:25]=imm[11:5] and inst[11:7]=imm[4:0].
REQ-021 SHALL pack B as inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5] and inst[11:8]=imm[4:1].
REQ-022 SHALL pack J as inst[31]=imm[20], inst[19:12]=imm[19:12], inst[20]=imm[11] and inst[30:21]=imm[10:1].
REQ-023 SHALL pack U as inst[31:12]=imm[31:12].
REQ-024 SHALL copy all non-immediate bits from base_inst; for type none, inst_out=base_inst and range_err=0.
REQ-025 SHALL assert range_err when any of the following holds: for I/S, imm[31:11] is not all-equal; for B, imm[31:12] is not all-equal or imm[0]=1; for J, imm[31:20] is not all-equal or imm[0]=1; for U, imm[11:0]!=0.
REQ-026 SHALL still emit the truncated packing when range_err=1.
REQ-027 SHALL increment emit_cnt by 1 per output handshake, wrapping from all-ones to 0.
REQ-028 SHALL increment err_cnt by 1 per handshake with range_err=1, saturating at 255.
REQ-029 SHALL keep a simultaneous accept and emit in one cycle lossless, with no bubble.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-transfer, asynchronously clear both stage valids, out_valid, range_err, inst_out, emit_cnt and err_cnt to 0, and discard in-flight items.
REQ-031 SHALL hold in_ready at 0 while rst=1 and at 1 in the first cycle after release.

Verification
REQ-032 SHALL cover: I, imm=0xFFFFF800, base=0x00000013 -> inst_out=0x80000013, range_err=0, 2 cycles later.
REQ-033 SHALL cover: B, imm=0x00000FFE, base=0x00000063 -> inst_out=0x7E000FE3, range_err=0; imm=0x00000FFF -> range_err=1, err_cnt=1.
REQ-034 SHALL cover: J, imm=0x00100000, base=0x0000006F -> range_err=1; U, imm=0x12345000, base=0x00000037 -> inst_out=0x12345037, range_err=0.
REQ-035 SHALL cover: out_ready low for 5 cycles with 3 requests -> in_ready falls after 2 accepts, outputs stable, all 3 delivered in order, emit_cnt=3.
REQ-036 SHALL cover: rst pulsed while both stages full -> out_valid=0 immediately, no stale output after release, counters 0.
REQ-037 SHALL cover: 1000 random encodable (ImmSel, imm) pairs -> decoding inst_out with the core's immediate generator returns imm.
